// File: rtl/ex_stage_mc.sv
// ex_stage_mc : execute stage with operand forwarding, a single-cycle ALU,
// an iterative shift-add multiplier and the EX/MEM pipeline register.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_valid_i               ID/EX holds a real instruction
//   rs_data_i, rt_data_i     register-file operands
//   imm_i                    sign-extended immediate
//   rs_i, rt_i, rd_i         source / destination register indices
//   alu_op_i                 000 add, 001 sub, 010 and, 011 or, 100 slt,
//                            101 sll, 110 srl, 111 mul
//   alu_src_i                0: B = forwarded rt, 1: B = immediate
//   reg_dst_i                0: dest = rt, 1: dest = rd
//   wb_ctrl_i                [1] RegWrite, [0] MemToReg
//   mem_read_i, mem_write_i, branch_i   memory / branch control
//   wb_wr_en_i, wb_wr_addr_i, wb_wr_data_i   WB-stage write port (forwarding)
//   flush_i                  squash the instruction in EX
//   stall_out_o              hold PC, IF/ID and ID/EX
//   mem_*_o                  EX/MEM register contents
module ex_stage_mc #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    input  logic [WIDTH-1:0]    rs_data_i,
    input  logic [WIDTH-1:0]    rt_data_i,
    input  logic [WIDTH-1:0]    imm_i,
    input  logic [REG_ADDR-1:0] rs_i,
    input  logic [REG_ADDR-1:0] rt_i,
    input  logic [REG_ADDR-1:0] rd_i,
    input  logic [2:0]          alu_op_i,
    input  logic                alu_src_i,
    input  logic                reg_dst_i,
    input  logic [1:0]          wb_ctrl_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic                branch_i,
    input  logic                wb_wr_en_i,
    input  logic [REG_ADDR-1:0] wb_wr_addr_i,
    input  logic [WIDTH-1:0]    wb_wr_data_i,
    input  logic                flush_i,
    output logic                stall_out_o,
    output logic                mem_valid_o,
    output logic [1:0]          mem_wb_ctrl_o,
    output logic                mem_read_en_o,
    output logic                mem_write_en_o,
    output logic                mem_branch_o,
    output logic                mem_zero_o,
    output logic [WIDTH-1:0]    mem_alu_result_o,
    output logic [WIDTH-1:0]    mem_write_data_o,
    output logic [REG_ADDR-1:0] mem_dest_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // EX/MEM register
    logic                mem_valid_q;
    logic [1:0]          mem_wb_ctrl_q;
    logic                mem_read_en_q;
    logic                mem_write_en_q;
    logic                mem_branch_q;
    logic                mem_zero_q;
    logic [WIDTH-1:0]    mem_alu_result_q;
    logic [WIDTH-1:0]    mem_write_data_q;
    logic [REG_ADDR-1:0] mem_dest_q;

    // multiplier state
    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             stall;

    // ------------------------------------------------------------------
    // Forwarding: index 0 is the rs path, index 1 the rt path.
    // EX/MEM wins over WB; register 0 is never forwarded.
    // ------------------------------------------------------------------
    logic [1:0][REG_ADDR-1:0] src_idx;
    logic [1:0][WIDTH-1:0]    src_data;
    logic [1:0][WIDTH-1:0]    fwd_val;

    assign src_idx[0]  = rs_i;
    assign src_idx[1]  = rt_i;
    assign src_data[0] = rs_data_i;
    assign src_data[1] = rt_data_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_mem;
            logic hit_wb;
            assign hit_mem = mem_valid_q && mem_wb_ctrl_q[1] &&
                             (mem_dest_q != '0) && (mem_dest_q == src_idx[gi]);
            assign hit_wb  = wb_wr_en_i && (wb_wr_addr_i != '0) &&
                             (wb_wr_addr_i == src_idx[gi]);
            assign fwd_val[gi] = hit_mem ? mem_alu_result_q :
                                 hit_wb  ? wb_wr_data_i     : src_data[gi];
        end
    endgenerate

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CW-1:0]    shamt;

    assign op_a  = fwd_val[0];
    assign op_b  = alu_src_i ? imm_i : fwd_val[1];
    assign shamt = op_b[CW-1:0];

    // ------------------------------------------------------------------
    // Single-cycle ALU; mul is produced by the iterative unit below.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] ex_result;

    always_comb begin
        alu_result = '0;
        case (alu_op_i)
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL:  alu_result = op_a << shamt;
            OP_SRL:  alu_result = op_a >> shamt;
            default: alu_result = '0;
        endcase
    end

    // In DONE the mul is still sitting in ID/EX, so its controls and
    // destination come straight from the inputs; only the data is swapped.
    assign ex_result = (state_q == S_DONE) ? acc_q : alu_result;

    // ------------------------------------------------------------------
    // Multiplier FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i && (alu_op_i == OP_MUL) && !flush_i) begin
                    // Latch now: forwarding sources drain away during the stall.
                    stall    = 1'b1;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                stall    = 1'b1;
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            stall   = 1'b0;
        end
    end

    // Gate with reset so the stall drops immediately when reset asserts,
    // even while a mul is waiting in ID/EX.
    assign stall_out_o = stall && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register: bubble on flush, stall or empty slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_valid_q      <= 1'b0;
            mem_wb_ctrl_q    <= '0;
            mem_read_en_q    <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_branch_q     <= 1'b0;
            mem_zero_q       <= 1'b0;
            mem_alu_result_q <= '0;
            mem_write_data_q <= '0;
            mem_dest_q       <= '0;
        end else if (flush_i || stall || !in_valid_i) begin
            mem_valid_q      <= 1'b0;
            mem_wb_ctrl_q    <= '0;
            mem_read_en_q    <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_branch_q     <= 1'b0;
            mem_zero_q       <= 1'b0;
            mem_alu_result_q <= '0;
            mem_write_data_q <= '0;
            mem_dest_q       <= '0;
        end else begin
            mem_valid_q      <= 1'b1;
            mem_wb_ctrl_q    <= wb_ctrl_i;
            mem_read_en_q    <= mem_read_i;
            mem_write_en_q   <= mem_write_i;
            mem_branch_q     <= branch_i;
            mem_zero_q       <= (ex_result == '0);
            mem_alu_result_q <= ex_result;
            mem_write_data_q <= fwd_val[1];
            mem_dest_q       <= reg_dst_i ? rd_i : rt_i;
        end
    end

    assign mem_valid_o      = mem_valid_q;
    assign mem_wb_ctrl_o    = mem_wb_ctrl_q;
    assign mem_read_en_o    = mem_read_en_q;
    assign mem_write_en_o   = mem_write_en_q;
    assign mem_branch_o     = mem_branch_q;
    assign mem_zero_o       = mem_zero_q;
    assign mem_alu_result_o = mem_alu_result_q;
    assign mem_write_data_o = mem_write_data_q;
    assign mem_dest_o       = mem_dest_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Testbench for ex_stage_mc: directed vectors, a cycle-level reference
// model checked on every falling edge, and literal expectations.
module tb_ex_stage_mc;

    localparam int W = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_i;
    logic [W-1:0] rs_data_i, rt_data_i, imm_i;
    logic [R-1:0] rs_i, rt_i, rd_i;
    logic [2:0]   alu_op_i;
    logic         alu_src_i, reg_dst_i;
    logic [1:0]   wb_ctrl_i;
    logic         mem_read_i, mem_write_i, branch_i;
    logic         wb_wr_en_i;
    logic [R-1:0] wb_wr_addr_i;
    logic [W-1:0] wb_wr_data_i;
    logic         flush_i;
    logic         stall_out_o, mem_valid_o;
    logic [1:0]   mem_wb_ctrl_o;
    logic         mem_read_en_o, mem_write_en_o, mem_branch_o, mem_zero_o;
    logic [W-1:0] mem_alu_result_o, mem_write_data_o;
    logic [R-1:0] mem_dest_o;

    ex_stage_mc #(.WIDTH(W), .REG_ADDR(R)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .alu_op_i(alu_op_i),
        .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i), .wb_ctrl_i(wb_ctrl_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .branch_i(branch_i),
        .wb_wr_en_i(wb_wr_en_i), .wb_wr_addr_i(wb_wr_addr_i),
        .wb_wr_data_i(wb_wr_data_i), .flush_i(flush_i),
        .stall_out_o(stall_out_o), .mem_valid_o(mem_valid_o),
        .mem_wb_ctrl_o(mem_wb_ctrl_o), .mem_read_en_o(mem_read_en_o),
        .mem_write_en_o(mem_write_en_o), .mem_branch_o(mem_branch_o),
        .mem_zero_o(mem_zero_o), .mem_alu_result_o(mem_alu_result_o),
        .mem_write_data_o(mem_write_data_o), .mem_dest_o(mem_dest_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: EX/MEM contents plus a cycle count since mul start.
    // m_mul_cyc = 0 means no mul in flight; 1..W are the stalled iteration
    // cycles; W+1 is the cycle the product is released.
    // ------------------------------------------------------------------
    logic         m_valid = 0, m_rd = 0, m_wr = 0, m_br = 0, m_zero = 0;
    logic [1:0]   m_ctrl = 0;
    logic [W-1:0] m_res = 0, m_wdata = 0, m_prod = 0;
    logic [R-1:0] m_dest = 0;
    int           m_mul_cyc = 0;

    logic [W-1:0] m_a, m_bt, m_b, m_next;
    logic         m_stall;

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        m_a = rs_data_i;
        if (m_valid && m_ctrl[1] && m_dest != 0 && m_dest == rs_i) m_a = m_res;
        else if (wb_wr_en_i && wb_wr_addr_i != 0 && wb_wr_addr_i == rs_i) m_a = wb_wr_data_i;
        m_bt = rt_data_i;
        if (m_valid && m_ctrl[1] && m_dest != 0 && m_dest == rt_i) m_bt = m_res;
        else if (wb_wr_en_i && wb_wr_addr_i != 0 && wb_wr_addr_i == rt_i) m_bt = wb_wr_data_i;
        m_b = alu_src_i ? imm_i : m_bt;
        m_next = (m_mul_cyc == W + 1) ? m_prod : ref_alu(alu_op_i, m_a, m_b);
        m_stall = 1'b0;
        if (rst_n && !flush_i) begin
            if (m_mul_cyc == 0) m_stall = in_valid_i && (alu_op_i == 3'b111);
            else                m_stall = (m_mul_cyc <= W);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_ctrl <= 0; m_rd <= 0; m_wr <= 0; m_br <= 0;
            m_zero <= 0; m_res <= 0; m_wdata <= 0; m_dest <= 0;
            m_mul_cyc <= 0; m_prod <= 0;
        end else if (flush_i || m_stall || !in_valid_i) begin
            m_valid <= 0; m_ctrl <= 0; m_rd <= 0; m_wr <= 0; m_br <= 0;
            m_zero <= 0; m_res <= 0; m_wdata <= 0; m_dest <= 0;
            if (flush_i || !m_stall) m_mul_cyc <= 0;
            else if (m_mul_cyc == 0) begin
                m_prod <= m_a * m_b;
                m_mul_cyc <= 1;
            end else m_mul_cyc <= m_mul_cyc + 1;
        end else begin
            m_valid <= 1; m_ctrl <= wb_ctrl_i; m_rd <= mem_read_i;
            m_wr <= mem_write_i; m_br <= branch_i;
            m_zero <= (m_next == 0); m_res <= m_next; m_wdata <= m_bt;
            m_dest <= reg_dst_i ? rd_i : rt_i;
            m_mul_cyc <= 0;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_stall",  32'(stall_out_o),    32'(m_stall));
        chk("cyc_valid",  32'(mem_valid_o),    32'(m_valid));
        chk("cyc_wbctrl", 32'(mem_wb_ctrl_o),  32'(m_ctrl));
        chk("cyc_rd",     32'(mem_read_en_o),  32'(m_rd));
        chk("cyc_wr",     32'(mem_write_en_o), 32'(m_wr));
        chk("cyc_br",     32'(mem_branch_o),   32'(m_br));
        chk("cyc_zero",   32'(mem_zero_o),     32'(m_zero));
        chk("cyc_result", mem_alu_result_o,    m_res);
        chk("cyc_wdata",  mem_write_data_o,    m_wdata);
        chk("cyc_dest",   32'(mem_dest_o),     32'(m_dest));
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_instr(input logic [2:0] op, input logic [R-1:0] rs, input logic [R-1:0] rt,
                             input logic [R-1:0] rd, input logic [W-1:0] rsd, input logic [W-1:0] rtd,
                             input logic [W-1:0] imm, input logic src, input logic [1:0] wbc,
                             input logic mw);
        in_valid_i = 1; alu_op_i = op; rs_i = rs; rt_i = rt; rd_i = rd;
        rs_data_i = rsd; rt_data_i = rtd; imm_i = imm; alu_src_i = src;
        reg_dst_i = 1; wb_ctrl_i = wbc; mem_read_i = 0; mem_write_i = mw; branch_i = 0;
        $display("txn op=%0d rs=%0d(%h) rt=%0d(%h) rd=%0d imm=%h src=%0d", op, rs, rsd, rt, rtd, rd, imm, src);
    endtask

    task automatic issue(input logic [2:0] op, input logic [R-1:0] rs, input logic [R-1:0] rt,
                         input logic [R-1:0] rd, input logic [W-1:0] rsd, input logic [W-1:0] rtd,
                         input logic [W-1:0] imm, input logic src, input logic [1:0] wbc,
                         input logic mw);
        set_instr(op, rs, rt, rd, rsd, rtd, imm, src, wbc, mw);
        @(posedge clk); #2;
    endtask

    int stall_cnt;
    int budget;

    initial begin
        rst_n = 1; in_valid_i = 0; rs_data_i = 0; rt_data_i = 0; imm_i = 0;
        rs_i = 0; rt_i = 0; rd_i = 0; alu_op_i = 0; alu_src_i = 0; reg_dst_i = 0;
        wb_ctrl_i = 0; mem_read_i = 0; mem_write_i = 0; branch_i = 0;
        wb_wr_en_i = 0; wb_wr_addr_i = 0; wb_wr_data_i = 0; flush_i = 0;
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid",  32'(mem_valid_o), 0);
        chk("reset_result", mem_alu_result_o, 0);
        chk("reset_stall",  32'(stall_out_o), 0);
        rst_n = 1;
        @(posedge clk); #2;

        // Forward priority: EX/MEM r3=0x10 beats WB r3=0x20.
        issue(3'd0, 5'd1, 5'd2, 5'd3, 32'h8, 32'h8, 0, 0, 2'b10, 0);
        chk("fwd_setup", mem_alu_result_o, 32'h10);
        wb_wr_en_i = 1; wb_wr_addr_i = 5'd3; wb_wr_data_i = 32'h20;
        issue(3'd0, 5'd3, 5'd0, 5'd4, 32'hDEAD, 0, 0, 0, 2'b10, 0);
        chk("fwd_mem_prio", mem_alu_result_o, 32'h10);
        chk("fwd_dest", 32'(mem_dest_o), 32'd4);
        issue(3'd0, 5'd3, 5'd0, 5'd6, 32'hDEAD, 0, 0, 0, 2'b00, 0);
        chk("fwd_wb", mem_alu_result_o, 32'h20);
        wb_wr_en_i = 0;

        // r0 is never forwarded, from either source.
        issue(3'd0, 5'd1, 5'd2, 5'd0, 32'h50, 32'h5, 0, 0, 2'b10, 0);
        chk("r0_setup", mem_alu_result_o, 32'h55);
        wb_wr_en_i = 1; wb_wr_addr_i = 5'd0; wb_wr_data_i = 32'h99;
        issue(3'd0, 5'd0, 5'd0, 5'd7, 0, 0, 0, 0, 2'b00, 0);
        chk("r0_guard", mem_alu_result_o, 0);
        chk("r0_zero", 32'(mem_zero_o), 1);
        wb_wr_en_i = 0;

        // Arithmetic corners.
        issue(3'd1, 5'd1, 5'd2, 5'd8, 32'h0, 32'h1, 0, 0, 2'b00, 0);
        chk("sub_wrap", mem_alu_result_o, 32'hFFFF_FFFF);
        chk("sub_zero", 32'(mem_zero_o), 0);
        issue(3'd4, 5'd1, 5'd2, 5'd8, 32'h8000_0000, 32'h1, 0, 0, 2'b00, 0);
        chk("slt_signed", mem_alu_result_o, 32'h1);
        issue(3'd6, 5'd1, 5'd2, 5'd8, 32'h8000_0000, 32'h0, 32'd31, 1, 2'b00, 0);
        chk("srl_31", mem_alu_result_o, 32'h1);
        issue(3'd2, 5'd1, 5'd2, 5'd8, 32'hF0, 32'h0F, 0, 0, 2'b00, 0);
        chk("and_zero_res", mem_alu_result_o, 0);
        chk("and_zero_flag", 32'(mem_zero_o), 1);
        issue(3'd3, 5'd1, 5'd2, 5'd8, 32'hF0, 32'h0F, 0, 0, 2'b00, 0);
        chk("or", mem_alu_result_o, 32'hFF);
        issue(3'd5, 5'd1, 5'd2, 5'd8, 32'h1, 32'h4, 0, 0, 2'b00, 0);
        chk("sll", mem_alu_result_o, 32'h10);
        issue(3'd0, 5'd1, 5'd2, 5'd9, 32'h100, 32'h1234, 32'h4, 1, 2'b00, 1);
        chk("store_addr", mem_alu_result_o, 32'h104);
        chk("store_data", mem_write_data_o, 32'h1234);
        chk("store_en", 32'(mem_write_en_o), 1);

        // Full multiply: stall for W+1 cycles, then the product.
        set_instr(3'd7, 5'd1, 5'd2, 5'd5, 32'h0000_FFFF, 32'h0001_0001, 0, 0, 2'b10, 0);
        stall_cnt = 0; budget = 0;
        #1;
        while (stall_out_o === 1'b1 && budget < 100) begin
            stall_cnt++;
            if (stall_cnt > 1) chk("mul_bubble", 32'(mem_valid_o), 0);
            @(posedge clk); #1;
            budget++;
        end
        chk("mul_stall_cycles", stall_cnt, W + 1);
        @(posedge clk); #2;
        chk("mul_result", mem_alu_result_o, 32'hFFFF_FFFF);
        chk("mul_valid", 32'(mem_valid_o), 1);
        chk("mul_dest", 32'(mem_dest_o), 32'd5);

        // Flush on cycle 5 of a multiply.
        set_instr(3'd7, 5'd1, 5'd2, 5'd5, 32'd7, 32'd6, 0, 0, 2'b10, 0);
        repeat (5) begin @(posedge clk); #2; end
        flush_i = 1;
        #1;
        chk("flush_stall", 32'(stall_out_o), 0);
        @(posedge clk); #2;
        chk("flush_bubble", 32'(mem_valid_o), 0);
        flush_i = 0;
        issue(3'd0, 5'd1, 5'd2, 5'd10, 32'd3, 32'd4, 0, 0, 2'b00, 0);
        chk("post_flush_add", mem_alu_result_o, 32'd7);
        chk("post_flush_valid", 32'(mem_valid_o), 1);

        // Reset mid-stream, then reset mid-multiply.
        issue(3'd0, 5'd1, 5'd2, 5'd11, 32'd5, 32'd6, 0, 0, 2'b00, 0);
        chk("pre_reset_add", mem_alu_result_o, 32'd11);
        rst_n = 0;
        #1;
        chk("rst_stream_result", mem_alu_result_o, 0);
        chk("rst_stream_valid", 32'(mem_valid_o), 0);
        @(posedge clk); #2;
        rst_n = 1;
        set_instr(3'd7, 5'd1, 5'd2, 5'd5, 32'd9, 32'd9, 0, 0, 2'b10, 0);
        repeat (3) begin @(posedge clk); #2; end
        rst_n = 0;
        #1;
        chk("rst_mul_stall", 32'(stall_out_o), 0);
        chk("rst_mul_valid", 32'(mem_valid_o), 0);
        chk("rst_mul_result", mem_alu_result_o, 0);
        @(posedge clk); #2;
        rst_n = 1;
        issue(3'd0, 5'd1, 5'd2, 5'd12, 32'd2, 32'd3, 0, 0, 2'b00, 0);
        chk("post_reset_add", mem_alu_result_o, 32'd5);
        chk("post_reset_valid", 32'(mem_valid_o), 1);

        in_valid_i = 0;
        repeat (3) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
